page_zigzag_merge8: RTL and testbench



---
 rtl/page_zigzag_merge8_pkg.sv | 28 ++
 rtl/page_zigzag_merge8_if.sv | 25 ++
 rtl/page_zigzag_merge8_rom.sv | 11 +
 rtl/page_zigzag_merge8.sv | 147 ++++++++++++++
 tb/tb_page_zigzag_merge8.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/page_zigzag_merge8_pkg.sv
// Shared constants, state encoding and the JPEG zigzag scan table for the
// zigzag merge page.
package page_zigzag_merge8_pkg;

    localparam int TOKEN_W = 16;
    localparam int BLK     = 64;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_DRAIN,
        ST_EOSIN,
        ST_EOSOUT,
        ST_DONE
    } state_e;

    // ZZ[k] is the raster index (row*8 + col) of the k-th coefficient in scan order.
    localparam logic [5:0] ZZ [BLK] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/page_zigzag_merge8_if.sv
// Token streams of the zigzag merge page: eight row inputs (index 0 = ruA,
// 7 = ruH) and the single zigzag-ordered output stream chuS.
interface page_zigzag_merge8_if;
    import page_zigzag_merge8_pkg::*;

    logic [7:0][TOKEN_W-1:0] ru_d;
    logic [7:0]              ru_e;
    logic [7:0]              ru_v;
    logic [7:0]              ru_b;
    logic [TOKEN_W-1:0]      chus_d;
    logic                    chus_e;
    logic                    chus_v;
    logic                    chus_b;

    modport slave (
        input  ru_d, ru_e, ru_v, chus_b,
        output ru_b, chus_d, chus_e, chus_v
    );

    modport master (
        output ru_d, ru_e, ru_v, chus_b,
        input  ru_b, chus_d, chus_e, chus_v
    );

endinterface

// File: rtl/page_zigzag_merge8_rom.sv
// Combinational zigzag lookup: scan position to raster buffer index.
module page_zigzag_merge8_rom
    import page_zigzag_merge8_pkg::*;
(
    input  logic [5:0] di_i,
    output logic [5:0] idx_o
);

    assign idx_o = ZZ[di_i];

endmodule

// File: rtl/page_zigzag_merge8.sv
// Gathers one 8x8 block from eight row streams and replays it in JPEG zigzag
// order; end-of-stream is collected from every row before a single eos token.
module page_zigzag_merge8
    import page_zigzag_merge8_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    page_zigzag_merge8_if.slave  bus
);

    state_e               state_q, state_d;
    logic [5:0]           fi_q, fi_d;
    logic [5:0]           di_q, di_d;
    logic [TOKEN_W-1:0]   od_q, od_d;
    logic                 oe_q, oe_d;
    logic                 ov_q, ov_d;
    logic [TOKEN_W-1:0]   buf_q [BLK];

    logic                 wr_en;
    logic [2:0]           sel;
    logic                 sel_v;
    logic                 sel_e;
    logic [TOKEN_W-1:0]   sel_d;
    logic                 out_xfer;
    logic [5:0]           rom_di;
    logic [5:0]           rom_idx;
    logic [7:0]           ru_b_w;

    // In EOSIN fi_q[5:3] doubles as the row whose eos is awaited.
    assign sel      = fi_q[5:3];
    assign sel_v    = bus.ru_v[sel];
    assign sel_e    = bus.ru_e[sel];
    assign sel_d    = bus.ru_d[sel];
    assign out_xfer = ov_q & ~bus.chus_b;

    // Address of the coefficient loaded next: scan position 0 when leaving
    // FILL, otherwise the position after the one currently presented.
    assign rom_di = (state_q == ST_DRAIN) ? di_q + 6'd1 : 6'd0;

    page_zigzag_merge8_rom u_rom (
        .di_i  (rom_di),
        .idx_o (rom_idx)
    );

    always_comb begin
        ru_b_w = '1;
        if (!reset && (state_q == ST_FILL || state_q == ST_EOSIN)) begin
            ru_b_w[sel] = 1'b0;
        end
    end

    assign bus.ru_b   = ru_b_w;
    assign bus.chus_d = od_q;
    assign bus.chus_e = oe_q;
    assign bus.chus_v = ov_q;

    always_comb begin
        state_d = state_q;
        fi_d    = fi_q;
        di_d    = di_q;
        od_d    = od_q;
        oe_d    = oe_q;
        ov_d    = ov_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (sel_v) begin
                    if (sel_e) begin
                        if (fi_q == 6'd0) begin
                            state_d = ST_EOSIN;
                            fi_d    = 6'd8;
                        end
                    end else begin
                        wr_en = 1'b1;
                        fi_d  = fi_q + 6'd1;
                        if (fi_q == 6'd63) begin
                            state_d = ST_DRAIN;
                            di_d    = 6'd0;
                            ov_d    = 1'b1;
                            oe_d    = 1'b0;
                            od_d    = buf_q[rom_idx];
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (out_xfer) begin
                    if (di_q == 6'd63) begin
                        state_d = ST_FILL;
                        fi_d    = 6'd0;
                        ov_d    = 1'b0;
                        od_d    = '0;
                    end else begin
                        di_d = di_q + 6'd1;
                        od_d = buf_q[rom_idx];
                    end
                end
            end
            ST_EOSIN: begin
                if (sel_v && sel_e) begin
                    if (sel == 3'd7) begin
                        state_d = ST_EOSOUT;
                        ov_d    = 1'b1;
                        oe_d    = 1'b1;
                        od_d    = '0;
                    end else begin
                        fi_d = fi_q + 6'd8;
                    end
                end
            end
            ST_EOSOUT: begin
                if (out_xfer) begin
                    state_d = ST_DONE;
                    ov_d    = 1'b0;
                    oe_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
            fi_q    <= 6'd0;
            di_q    <= 6'd0;
            od_q    <= '0;
            oe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fi_q    <= fi_d;
            di_q    <= di_d;
            od_q    <= od_d;
            oe_q    <= oe_d;
            ov_q    <= ov_d;
        end
    end

    // Block contents are don't-care after reset, so the buffer has no reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            buf_q[fi_q] <= sel_d;
        end
    end

endmodule

// File: tb/tb_page_zigzag_merge8.sv
// Randomized bench for page_zigzag_merge8 against a block-level model that
// derives the zigzag scan by walking anti-diagonals.
module tb_page_zigzag_merge8;

    localparam int P_FILL   = 0;
    localparam int P_DRAIN  = 1;
    localparam int P_EOSIN  = 2;
    localparam int P_EOSOUT = 3;
    localparam int P_DONE   = 4;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } tok_t;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    page_zigzag_merge8_if u_bus ();

    page_zigzag_merge8 u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_bus)
    );

    tok_t        rq [8][$];
    int          zz [64];
    logic [15:0] m_blk [64];
    int          m_phase;
    int          m_cnt;
    int          m_dcnt;
    int          m_erow;
    int          blocks_done;
    int          v_pct;
    int          b_mode;
    int          b_ctr;
    int          n_cmp;
    int          n_bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic build_zz();
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_phase = P_FILL;
        m_cnt   = 0;
        m_dcnt  = 0;
        m_erow  = 0;
        for (int r = 0; r < 8; r++) rq[r].delete();
    endtask

    task automatic load_block(input bit seq, input bit mid_eos);
        tok_t t;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (mid_eos && r == 2 && c == 4) begin
                    t.d = 16'($urandom);
                    t.e = 1'b1;
                    rq[r].push_back(t);
                end
                t.d = seq ? 16'(r * 8 + c) : 16'($urandom);
                t.e = 1'b0;
                rq[r].push_back(t);
            end
        end
    endtask

    task automatic load_eos();
        tok_t t;
        for (int r = 0; r < 8; r++) begin
            t.d = 16'($urandom);
            t.e = 1'b1;
            rq[r].push_back(t);
        end
    endtask

    // One cycle: drive at the falling edge, check the settled outputs, then
    // advance the model by whatever the coming rising edge will transfer.
    task automatic step();
        bit         vdr [8];
        bit         bdr;
        logic [7:0] exp_b;
        int         sel;
        tok_t       t;
        @(negedge clock);
        for (int r = 0; r < 8; r++) begin
            if (rq[r].size() > 0 && $urandom_range(99) < v_pct) begin
                vdr[r]          = 1'b1;
                u_bus.ru_v[r] = 1'b1;
                u_bus.ru_d[r] = rq[r][0].d;
                u_bus.ru_e[r] = rq[r][0].e;
            end else begin
                vdr[r]          = 1'b0;
                u_bus.ru_v[r] = 1'b0;
                u_bus.ru_d[r] = 16'($urandom);
                u_bus.ru_e[r] = 1'($urandom);
            end
        end
        case (b_mode)
            1:       bdr = (b_ctr % 3) != 2;
            2:       bdr = 1'($urandom_range(1));
            default: bdr = 1'b0;
        endcase
        b_ctr++;
        u_bus.chus_b = bdr;
        #1;
        exp_b = 8'hFF;
        if (m_phase == P_FILL)  exp_b[m_cnt / 8] = 1'b0;
        if (m_phase == P_EOSIN) exp_b[m_erow]    = 1'b0;
        check_eq("ru_b", 32'(u_bus.ru_b), 32'(exp_b));
        check_eq("chus_v", 32'(u_bus.chus_v), 32'(m_phase == P_DRAIN || m_phase == P_EOSOUT));
        if (m_phase == P_DRAIN) begin
            check_eq("chus_d", 32'(u_bus.chus_d), 32'(m_blk[zz[m_dcnt]]));
            check_eq("chus_e", 32'(u_bus.chus_e), 32'(0));
        end else if (m_phase == P_EOSOUT) begin
            check_eq("eos_d", 32'(u_bus.chus_d), 32'(0));
            check_eq("eos_e", 32'(u_bus.chus_e), 32'(1));
        end
        if (m_phase == P_FILL || m_phase == P_EOSIN) begin
            sel = (m_phase == P_FILL) ? m_cnt / 8 : m_erow;
            if (vdr[sel]) begin
                t = rq[sel].pop_front();
                if (m_phase == P_FILL) begin
                    if (t.e) begin
                        if (m_cnt == 0) begin
                            m_phase = P_EOSIN;
                            m_erow  = 1;
                        end
                    end else begin
                        m_blk[m_cnt] = t.d;
                        m_cnt++;
                        if (m_cnt == 64) begin
                            m_phase = P_DRAIN;
                            m_dcnt  = 0;
                        end
                    end
                end else if (t.e) begin
                    if (m_erow == 7) m_phase = P_EOSOUT;
                    else             m_erow++;
                end
            end
        end else if (m_phase == P_DRAIN && !bdr) begin
            m_dcnt++;
            if (m_dcnt == 64) begin
                m_phase = P_FILL;
                m_cnt   = 0;
                blocks_done++;
            end
        end else if (m_phase == P_EOSOUT && !bdr) begin
            m_phase = P_DONE;
        end
    endtask

    task automatic run_blocks(input int target);
        int guard;
        guard = 0;
        while (blocks_done < target && guard < 3000) begin
            step();
            guard++;
        end
        if (blocks_done < target) check_eq("block_timeout", 32'(blocks_done), 32'(target));
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("rst_chus_v", 32'(u_bus.chus_v), 32'(0));
        check_eq("rst_chus_e", 32'(u_bus.chus_e), 32'(0));
        check_eq("rst_chus_d", 32'(u_bus.chus_d), 32'(0));
        check_eq("rst_ru_b", 32'(u_bus.ru_b), 32'(8'hFF));
        model_reset();
        u_bus.ru_v   = '0;
        u_bus.chus_b = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        n_cmp        = 0;
        n_bad        = 0;
        blocks_done  = 0;
        b_ctr        = 0;
        reset        = 1'b1;
        u_bus.ru_d   = '0;
        u_bus.ru_e   = '0;
        u_bus.ru_v   = '0;
        u_bus.chus_b = 1'b0;
        build_zz();
        model_reset();
        apply_reset();

        // sequential data, no stalls: output must equal the scan table itself
        v_pct  = 100;
        b_mode = 0;
        load_block(1'b1, 1'b0);
        run_blocks(1);

        // output back-pressure 1,1,0
        b_mode = 1;
        load_block(1'b1, 1'b0);
        run_blocks(2);

        // input gaps, random output stalls, random data
        v_pct  = 60;
        b_mode = 2;
        load_block(1'b0, 1'b0);
        load_block(1'b0, 1'b0);
        run_blocks(4);

        // eos on ruC at fi=20 is discarded
        v_pct  = 80;
        b_mode = 0;
        load_block(1'b1, 1'b1);
        run_blocks(5);

        // reset after ten output transfers, then a fresh block
        b_mode = 2;
        load_block(1'b0, 1'b0);
        guard = 0;
        while (!(m_phase == P_DRAIN && m_dcnt == 10) && guard < 3000) begin
            step();
            guard++;
        end
        check_eq("reach_drain10", 32'(m_dcnt), 32'(10));
        apply_reset();
        b_mode = 0;
        load_block(1'b1, 1'b0);
        run_blocks(6);

        // end of stream after one more block
        v_pct  = 70;
        b_mode = 2;
        load_block(1'b0, 1'b0);
        load_eos();
        guard = 0;
        while (m_phase != P_DONE && guard < 3000) begin
            step();
            guard++;
        end
        check_eq("reach_done", 32'(m_phase), 32'(P_DONE));
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
